// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings and the baud divisor helper,
// used by the transmitter and the receiver.
package uart_defs;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Integer divide; the result must be >= 2 for the baud counter to be meaningful.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Show-ahead FIFO read port between the CPU's outbound character FIFO (master)
// and the UART transmitter that drains it (slave).
interface uart_tx_drain_if #(
    parameter int ITEM_BITS = 32
);
    logic [ITEM_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_read;

    modport master (output fifo_data, output fifo_empty, input fifo_read);
    modport slave  (input fifo_data, input fifo_empty, output fifo_read);
endinterface

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period timer shared by the UART transmitter and receiver: counts
// 0..CLKS_PER_BIT-1 and pulses bit_done on the terminal count.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLOCK_50,
    input  logic RST_N,
    input  logic clear,
    output logic bit_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_done = !clear && (cnt_q == LAST);

    always_comb begin
        // NOTE: the default assignment first means every path writes cnt_d, so no latch is inferred.
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) cnt_d = '0;
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a show-ahead FIFO, 8N1 by default; defining
// UART_TX_PARITY_EN adds one even-parity bit (8E1).
module uart_tx_drain
    import uart_defs::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int ITEM_BITS = 32
) (
    input  logic           CLOCK_50,
    input  logic           RST_N,
    uart_tx_drain_if.slave fifo,
    output logic           tx,
    output logic           busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
    logic                 pop;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Bits of the head word above DATA_BITS are deliberately discarded.
    logic [ITEM_BITS-1:0] unused_word;
    assign unused_word = fifo.fifo_data;

    assign pop            = (state_q == IDLE) && !fifo.fifo_empty && RST_N;
    assign fifo.fifo_read = pop;
    assign tx             = tx_q;
    assign busy           = busy_q;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .clear    (state_q == IDLE),
        .bit_done (bit_done)
    );

    // tx_d is the line level for the state being entered, so tx stays registered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: if (pop) begin
                state_d   = START;
                shift_d   = fifo.fifo_data[DATA_BITS-1:0];
                bit_idx_d = '0;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^fifo.fifo_data[DATA_BITS-1:0];
`endif
            end
            START: if (bit_done) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_done) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == LAST_DATA) begin
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = PARITY;
                    tx_d      = parity_q;
`else
                    state_d   = STOP;
                    tx_d      = 1'b1;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    tx_d      = shift_d[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (bit_done) begin
                if (bit_idx_q == LAST_STOP) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end
endmodule
